ir_conv_engine: RTL and testbench
=================================

Name: ir_conv_engine

Overview:
- Per-sample FIR convolution engine directly downstream of the 24000-tap reversed IR store.
- On each input audio sample it sweeps the store's two read indices over all taps.
- Each cycle it multiplies the eight IR lanes by eight time-aligned audio-history lanes and accumulates.
- It emits one saturated 16-bit wet sample per input sample.

Parameters:
- TAPS_PER_PORT, 3000: read indices swept per sample. first index = k, second index = k + TAPS_PER_PORT, for k = 0..TAPS_PER_PORT-1.
- RAM_LATENCY, 2: cycles from index driven to ir_vals/hist_vals valid.
- ACC_WIDTH, 48: signed accumulator width.
- OUT_SHIFT, 15: arithmetic right shift applied to the accumulator before saturation.

Ports:
- audio_clk  in  1  system clock.
- rst_in  in  1  synchronous active-high reset.
- audio_sample_valid  in  1  one-cycle pulse; a new audio sample has been written to the history buffer.
- first_ir_index  out  13  port-A read index to the IR store and the history buffer.
- second_ir_index  out  13  port-B read index to the IR store and the history buffer.
- ir_vals  in  8x16 signed  IR lanes; lane 2b is port A of bank b, lane 2b+1 is port B of bank b.
- hist_vals  in  8x16 signed  audio-history lanes, same lane/latency mapping as ir_vals.
- conv_out  out  16 signed  convolution result.
- conv_out_valid  out  1  one-cycle pulse; conv_out updated.
- busy  out  1  high from sweep start until the conv_out_valid cycle inclusive.
- overrun  out  1  one-cycle pulse when audio_sample_valid arrives while busy.

Behaviour:
- Reset values: first_ir_index=0, second_ir_index=TAPS_PER_PORT, conv_out=0, conv_out_valid=0, busy=0, overrun=0.
- Reset also clears the accumulator, all pipeline valid bits and the FSM (state IDLE).
- FSM states and transitions:
  - IDLE: on audio_sample_valid: k<=0, clear accumulator, go to SWEEP.
  - SWEEP: k increments each cycle. After k = TAPS_PER_PORT-1 is driven, go to DRAIN.
  - DRAIN: wait until the last tap has been accumulated, then go to OUTPUT.
  - OUTPUT: register conv_out, pulse conv_out_valid, go to IDLE.
- Index outputs are registered: first_ir_index=k, second_ir_index=k+TAPS_PER_PORT. In IDLE they hold at 0 / TAPS_PER_PORT.
- Pipeline, with a valid bit per stage:
  - Index k is driven in cycle c; lane data is valid in cycle c+RAM_LATENCY.
  - Eight signed 16x16 products (32b) are registered.
  - The products are summed by an adder tree (35b) and registered.
  - The tree result is sign-extended and added into the accumulator.
- Latency: conv_out_valid pulses exactly TAPS_PER_PORT+RAM_LATENCY+4 cycles after the cycle in which audio_sample_valid was sampled. For defaults: 3006 cycles.
- Output arithmetic:
  - Arithmetic shift of the accumulator right by OUT_SHIFT, truncating toward -inf.
  - Saturate to [-32768, 32767].
  - conv_out holds its value between pulses.
- audio_sample_valid while busy: the sample is ignored, overrun pulses for that cycle, and the current sweep is unaffected.
- audio_sample_valid in the same cycle as conv_out_valid: busy is still high, so it is treated as an overrun.
- rst_in mid-sweep: the sweep is aborted with no conv_out_valid; the next audio_sample_valid starts a clean sweep.
- The accumulator never wraps for full-scale inputs at the defaults (24000 x 2^30 < 2^47).

Test Plan:
- Reset, then idle 10 cycles -> outputs at reset values; indices 0/3000; busy=0.
- TAPS_PER_PORT=4; drive lane-0 ir=32767 and hist=1000 only when the index equals 0, all else 0; pulse valid -> conv_out=999, conv_out_valid exactly 4+2+4=10 cycles after valid, busy high for those cycles.
- Same setup with hist=-1000 -> conv_out=-1000 (floor rounding).
- TAPS_PER_PORT=4; all lanes ir=hist=16384 every cycle -> accumulator 2^33, shifted 2^18 -> conv_out=32767 (saturation). All ir=16384, all hist=-16384 -> conv_out=-32768.
- Pulse valid again 3 cycles into a sweep -> overrun pulses once; a single conv_out_valid with an unchanged result; the index sequence k=0..3 is uninterrupted.
- Assert rst_in mid-SWEEP, then pulse valid -> no output from the aborted sweep; the new result equals a clean single-sample run with the same stimulus.

Source files
------------

// File: rtl/ir_conv_engine.sv
// Per-sample FIR convolution over the reversed IR store: sweeps both read ports,
// multiplies eight IR lanes by eight history lanes per cycle and accumulates.
module ir_conv_engine #(
   parameter int unsigned TAPS_PER_PORT = 3000,
   parameter int unsigned RAM_LATENCY   = 2,
   parameter int unsigned ACC_WIDTH     = 48,
   parameter int unsigned OUT_SHIFT     = 15
) (
   input  logic                audio_clk,
   input  logic                rst_in,
   input  logic                audio_sample_valid,
   output logic [12:0]         first_ir_index,
   output logic [12:0]         second_ir_index,
   input  logic [7:0][15:0]    ir_vals,
   input  logic [7:0][15:0]    hist_vals,
   output logic signed [15:0]  conv_out,
   output logic                conv_out_valid,
   output logic                busy,
   output logic                overrun
);

   localparam int unsigned IDX_W  = 13;
   localparam int unsigned LANES  = 8;
   localparam int unsigned PROD_W = 32;
   localparam int unsigned TREE_W = 35;
   localparam int unsigned OUT_W  = 16;
   localparam int unsigned HI_W   = ACC_WIDTH - OUT_W + 1;

   localparam logic [IDX_W-1:0]        LAST_K     = IDX_W'(TAPS_PER_PORT - 1);
   localparam logic [IDX_W-1:0]        PORT_B_OFS = IDX_W'(TAPS_PER_PORT);
   localparam logic signed [OUT_W-1:0] SAT_MAX    = {1'b0, {(OUT_W-1){1'b1}}};
   localparam logic signed [OUT_W-1:0] SAT_MIN    = {1'b1, {(OUT_W-1){1'b0}}};

   typedef enum logic [1:0] {S_IDLE, S_SWEEP, S_DRAIN, S_OUTPUT} state_t;

   state_t                   state_q, state_d;
   logic [IDX_W-1:0]         first_q, first_d, second_q, second_d;
   logic [RAM_LATENCY-1:0]   lane_v_q, lane_v_d;
   logic signed [PROD_W-1:0] prod_q [LANES];
   logic signed [PROD_W-1:0] prod_d [LANES];
   logic                     prod_v_q, prod_v_d;
   logic signed [TREE_W-1:0] tree_q, tree_d;
   logic                     tree_v_q, tree_v_d;
   logic signed [ACC_WIDTH-1:0] acc_q, acc_d, acc_shr;
   logic [HI_W-1:0]          acc_hi;
   logic signed [OUT_W-1:0]  sat_val;
   logic signed [OUT_W-1:0]  conv_q, conv_d;
   logic                     valid_q, valid_d, busy_q, busy_d, ovr_q, ovr_d;

   // Multiply, adder tree and saturation; each stage tagged by a valid bit
   always_comb begin : datapath
      lane_v_d = RAM_LATENCY'({lane_v_q, state_q == S_SWEEP});
      prod_v_d = lane_v_q[RAM_LATENCY-1];
      tree_v_d = prod_v_q;
      tree_d   = '0;
      for (int i = 0; i < LANES; i++) begin
         prod_d[i] = PROD_W'($signed(ir_vals[i])) * PROD_W'($signed(hist_vals[i]));
         tree_d    = tree_d + TREE_W'(prod_q[i]);
      end
      acc_shr = acc_q >>> OUT_SHIFT;
      acc_hi  = acc_shr[ACC_WIDTH-1:OUT_W-1];
      if ((&acc_hi) || !(|acc_hi)) begin
         sat_val = OUT_W'(acc_shr);
      end else begin
         sat_val = acc_hi[HI_W-1] ? SAT_MIN : SAT_MAX;
      end
   end

   always_comb begin : fsm_next
      state_d  = state_q;
      first_d  = first_q;
      acc_d    = acc_q;
      conv_d   = conv_q;
      valid_d  = 1'b0;
      ovr_d    = audio_sample_valid & busy_q;
      if (tree_v_q) begin
         acc_d = acc_q + ACC_WIDTH'(tree_q);
      end
      case (state_q)
         S_IDLE: begin
            // busy_q still covers the conv_out_valid cycle, so a sample there is an overrun
            if (audio_sample_valid && !busy_q) begin
               state_d = S_SWEEP;
               first_d = '0;
               acc_d   = '0;
            end
         end
         S_SWEEP: begin
            if (first_q == LAST_K) begin
               state_d = S_DRAIN;
               first_d = '0;
            end else begin
               first_d = first_q + IDX_W'(1);
            end
         end
         S_DRAIN: begin
            if (tree_v_q && !prod_v_q && !(|lane_v_q)) begin
               state_d = S_OUTPUT;
            end
         end
         S_OUTPUT: begin
            conv_d  = sat_val;
            valid_d = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      second_d = first_d + PORT_B_OFS;
      busy_d   = (state_d != S_IDLE) || valid_d;
   end

   always_ff @(posedge audio_clk) begin : ctrl_regs
      if (rst_in) begin
         state_q  <= S_IDLE;
         first_q  <= '0;
         second_q <= PORT_B_OFS;
         lane_v_q <= '0;
         prod_v_q <= 1'b0;
         tree_v_q <= 1'b0;
         acc_q    <= '0;
         conv_q   <= '0;
         valid_q  <= 1'b0;
         busy_q   <= 1'b0;
         ovr_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         first_q  <= first_d;
         second_q <= second_d;
         lane_v_q <= lane_v_d;
         prod_v_q <= prod_v_d;
         tree_v_q <= tree_v_d;
         acc_q    <= acc_d;
         conv_q   <= conv_d;
         valid_q  <= valid_d;
         busy_q   <= busy_d;
         ovr_q    <= ovr_d;
      end
   end

   always_ff @(posedge audio_clk) begin : data_regs
      prod_q <= prod_d;
      tree_q <= tree_d;
   end

   assign first_ir_index  = first_q;
   assign second_ir_index = second_q;
   assign conv_out        = conv_q;
   assign conv_out_valid  = valid_q;
   assign busy            = busy_q;
   assign overrun         = ovr_q;

endmodule

// File: tb/tb_ir_conv_engine.sv
// Randomized bench for ir_conv_engine: emulates the IR/history RAMs and compares
// each wet sample with a floor-shift-saturate model of the full dot product.
module tb_ir_conv_engine;

   localparam int unsigned T       = 4;
   localparam int unsigned RUN_LEN = T + 8;

   logic               clk = 1'b0;
   logic               rst = 1'b1;
   logic               asv = 1'b0;
   logic [12:0]        first_idx, second_idx;
   logic [7:0][15:0]   ir_vals = '0, hist_vals = '0, ir_rd1 = '0, hist_rd1 = '0;
   logic signed [15:0] conv_out;
   logic               conv_out_valid, busy, overrun;

   logic signed [15:0] ir_mem   [4][2*T];
   logic signed [15:0] hist_mem [4][2*T];

   int n_checks = 0;
   int n_fail   = 0;

   ir_conv_engine #(
      .TAPS_PER_PORT (T),
      .RAM_LATENCY   (2),
      .ACC_WIDTH     (48),
      .OUT_SHIFT     (15)
   ) dut (
      .audio_clk          (clk),
      .rst_in             (rst),
      .audio_sample_valid (asv),
      .first_ir_index     (first_idx),
      .second_ir_index    (second_idx),
      .ir_vals            (ir_vals),
      .hist_vals          (hist_vals),
      .conv_out           (conv_out),
      .conv_out_valid     (conv_out_valid),
      .busy               (busy),
      .overrun            (overrun)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] mem_rd(input bit use_hist, input int bk, input logic [12:0] addr);
      if (int'(addr) >= int'(2*T)) return 16'h0;
      return use_hist ? hist_mem[bk][int'(addr)] : ir_mem[bk][int'(addr)];
   endfunction

   // Lane 2b reads bank b at the port-A index, lane 2b+1 at the port-B index
   function automatic logic [7:0][15:0] rd_lanes(input bit use_hist, input logic [12:0] a, input logic [12:0] b);
      logic [7:0][15:0] v;
      for (int bk = 0; bk < 4; bk++) begin
         v[2*bk]   = mem_rd(use_hist, bk, a);
         v[2*bk+1] = mem_rd(use_hist, bk, b);
      end
      return v;
   endfunction

   // Two-cycle RAM read model
   always @(posedge clk) begin
      ir_rd1    <= rd_lanes(1'b0, first_idx, second_idx);
      hist_rd1  <= rd_lanes(1'b1, first_idx, second_idx);
      ir_vals   <= ir_rd1;
      hist_vals <= hist_rd1;
   end

   function automatic logic signed [15:0] model_out();
      longint s = 0;
      longint q;
      for (int bk = 0; bk < 4; bk++)
         for (int a = 0; a < int'(2*T); a++)
            s += longint'(ir_mem[bk][a]) * longint'(hist_mem[bk][a]);
      q = s / 32768;
      if (s < 0 && q * 32768 != s) q = q - 1;
      if (q > 32767)  return 16'sh7fff;
      if (q < -32768) return 16'sh8000;
      return 16'(q);
   endfunction

   task automatic check_val(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp_v);
      n_checks++;
      if (obs !== exp_v) begin
         n_fail++;
         $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp_v);
      end
   endtask

   task automatic fill_const(input int ir_v, input int hist_v);
      for (int bk = 0; bk < 4; bk++)
         for (int a = 0; a < int'(2*T); a++) begin
            ir_mem[bk][a]   = 16'(ir_v);
            hist_mem[bk][a] = 16'(hist_v);
         end
   endtask

   task automatic fill_rand(input bit full_scale, input int amp);
      for (int bk = 0; bk < 4; bk++)
         for (int a = 0; a < int'(2*T); a++) begin
            if (full_scale) begin
               ir_mem[bk][a]   = 16'($urandom());
               hist_mem[bk][a] = 16'($urandom());
            end else begin
               ir_mem[bk][a]   = 16'(int'($urandom_range(0, 2*amp)) - amp);
               hist_mem[bk][a] = 16'(int'($urandom_range(0, 2*amp)) - amp);
            end
         end
   endtask

   // One sample; cycle n counts from the sampling edge. ovr_at>0 pulses a second sample in cycle n=ovr_at
   task automatic run_sample(input string tag, input int ovr_at);
      logic signed [15:0] exp_v;
      exp_v = model_out();
      @(negedge clk); asv = 1'b1;
      @(negedge clk); asv = 1'b0;
      for (int n = 1; n <= int'(RUN_LEN); n++) begin
         if (n <= int'(T)) begin
            check_val({tag, ".idx_a"}, first_idx, n - 1);
            check_val({tag, ".idx_b"}, second_idx, n - 1 + int'(T));
         end
         check_val({tag, ".busy"}, busy, n <= int'(T) + 6);
         check_val({tag, ".valid"}, conv_out_valid, n == int'(T) + 6);
         check_val({tag, ".overrun"}, overrun, ovr_at > 0 && n == ovr_at + 1);
         if (n >= int'(T) + 6) check_val({tag, ".out"}, conv_out, exp_v);
         asv = (n == ovr_at);
         @(negedge clk);
      end
      asv = 1'b0;
   endtask

   initial begin
      fill_const(0, 0);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (10) @(negedge clk);
      check_val("rst.idx_a", first_idx, 0);
      check_val("rst.idx_b", second_idx, T);
      check_val("rst.out", conv_out, 0);
      check_val("rst.valid", conv_out_valid, 0);
      check_val("rst.busy", busy, 0);
      check_val("rst.overrun", overrun, 0);

      fill_const(0, 0);
      ir_mem[0][0] = 16'sd32767; hist_mem[0][0] = 16'sd1000;
      run_sample("dir_pos", 0);
      check_val("dir_pos.value", conv_out, 999);

      hist_mem[0][0] = -16'sd1000;
      run_sample("dir_neg", 0);
      check_val("dir_neg.value", conv_out, -1000);

      fill_const(16384, 16384);
      run_sample("sat_pos", 0);
      check_val("sat_pos.value", conv_out, 32767);
      fill_const(16384, -16384);
      run_sample("sat_neg", 0);
      check_val("sat_neg.value", conv_out, -32768);

      fill_rand(1'b0, 3000);
      run_sample("ovr_mid", 3);
      run_sample("ovr_edge", T + 6);

      // Abort a sweep with reset, then rerun the same stimulus cleanly
      fill_rand(1'b0, 5000);
      @(negedge clk); asv = 1'b1;
      @(negedge clk); asv = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk); rst = 1'b0;
      for (int n = 0; n < 12; n++) begin
         check_val("abort.valid", conv_out_valid, 0);
         check_val("abort.busy", busy, 0);
         check_val("abort.idx_a", first_idx, 0);
         check_val("abort.idx_b", second_idx, T);
         @(negedge clk);
      end
      check_val("abort.out", conv_out, 0);
      run_sample("post_rst", 0);

      for (int it = 0; it < 30; it++) begin
         int ovr;
         fill_rand(it % 4 == 0, int'($urandom_range(100, 8000)));
         ovr = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, T + 6)) : 0;
         run_sample("rand", ovr);
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
